word_serial_adder: RTL and testbench



---
 rtl/word_serial_adder.sv | 119 +++++++++++
 tb/tb_word_serial_adder.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_serial_adder.sv
// Word-serial wide adder: sequences an N*WORDS-bit add through one external N-bit adder.
// Optional subtract mode is compiled in with `define WORD_SERIAL_ADDER_SUB_EN.
module word_serial_adder #(
    parameter int unsigned N     = 8,
    parameter int unsigned WORDS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [N*WORDS-1:0]   op_a,
    input  logic [N*WORDS-1:0]   op_b,
`ifdef WORD_SERIAL_ADDER_SUB_EN
    input  logic                 sub,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [N*WORDS-1:0]   result,
    output logic                 carry_out,
    output logic [N-1:0]         add_a,
    output logic [N-1:0]         add_b,
    output logic                 add_cin,
    input  logic [N-1:0]         add_sum,
    input  logic                 add_cout
);

    localparam int unsigned W  = N * WORDS;
    localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            c_q;
    logic [W-1:0]    result_q;
    logic            carry_q;
    logic            busy_q;
    logic            done_q;
    logic            sub_c;

`ifdef WORD_SERIAL_ADDER_SUB_EN
    assign sub_c = sub;
`else
    assign sub_c = 1'b0;
`endif

    // Operand registers shift down one word per RUN cycle, so the adder always sees bits [N-1:0];
    // they are cleared on leaving RUN, which keeps add_a/add_b/add_cin at zero outside RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q      <= op_a;
                        b_q      <= sub_c ? ~op_b : op_b;
                        c_q      <= sub_c;
                        idx_q    <= '0;
                        result_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int unsigned w = 0; w < WORDS; w++) begin
                        if (idx_q == IW'(w)) begin
                            result_q[w*N +: N] <= add_sum;
                        end
                    end
                    if (idx_q == IW'(WORDS - 1)) begin
                        carry_q <= add_cout;
                        c_q     <= 1'b0;
                        a_q     <= '0;
                        b_q     <= '0;
                        idx_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        c_q   <= add_cout;
                        a_q   <= a_q >> N;
                        b_q   <= b_q >> N;
                        idx_q <= idx_q + IW'(1);
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign add_a     = a_q[N-1:0];
    assign add_b     = b_q[N-1:0];
    assign add_cin   = c_q;
    assign result    = result_q;
    assign carry_out = carry_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_word_serial_adder.sv
// Self-checking bench for word_serial_adder with an attached behavioural N-bit adder.
module tb_word_serial_adder;

    localparam int unsigned N     = 8;
    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = N * WORDS;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
`ifdef WORD_SERIAL_ADDER_SUB_EN
    logic           sub;
`endif
    logic           busy;
    logic           done;
    logic [W-1:0]   result;
    logic           carry_out;
    logic [N-1:0]   add_a;
    logic [N-1:0]   add_b;
    logic           add_cin;
    logic [N-1:0]   add_sum;
    logic           add_cout;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};

    word_serial_adder #(.N(N), .WORDS(WORDS)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
`ifdef WORD_SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
    );

    // Reference: {carry_out, result} of the wide operation.
    function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W-1:0] diff;
        if (s) begin
            diff = a - b;
            return {(a >= b), diff};
        end
        return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Advances until done is seen or the budget expires; lat counts cycles after the accept edge.
    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 4 * WORDS) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        tick();
        tick();
        vectors++;
        if ({busy, done, carry_out} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: busy/done/carry_out got %b expected 000", {busy, done, carry_out});
        end
        vectors++;
        if (result !== '0) begin
            errors++;
            $display("FAIL reset_result: got %h expected 0", result);
        end
        vectors++;
        if ({add_a, add_b, add_cin} !== '0) begin
            errors++;
            $display("FAIL reset_adder: got a=%h b=%h cin=%b expected zeros", add_a, add_b, add_cin);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic [W:0] exp;
        exp = ref_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
        start_op(32'h0000_00FF, 32'h0000_0001);
        for (int cyc = 1; cyc <= 6; cyc++) begin
            vectors++;
            if (busy !== (cyc <= 5)) begin
                errors++;
                $display("FAIL directed_busy c%0d: got %b expected %b", cyc, busy, (cyc <= 5));
            end
            vectors++;
            if (done !== (cyc == 5)) begin
                errors++;
                $display("FAIL directed_done c%0d: got %b expected %b", cyc, done, (cyc == 5));
            end
            if (cyc == 5) begin
                vectors++;
                if ({carry_out, result} !== exp || result !== 32'h0000_0100) begin
                    errors++;
                    $display("FAIL directed_result: got %b_%h expected %b_%h", carry_out, result, exp[W], exp[W-1:0]);
                end
            end
            tick();
        end
    endtask

    task automatic test_carry_chain();
        start_op(32'hFFFF_FFFF, 32'h0000_0001);
        for (int cyc = 1; cyc <= 4; cyc++) begin
            vectors++;
            if (add_cin !== (cyc >= 2) || add_a !== 8'hFF || add_b !== ((cyc == 1) ? 8'h01 : 8'h00)) begin
                errors++;
                $display("FAIL carry_chain c%0d: got a=%h b=%h cin=%b", cyc, add_a, add_b, add_cin);
            end
            tick();
        end
        vectors++;
        if (done !== 1'b1 || result !== 32'h0 || carry_out !== 1'b1) begin
            errors++;
            $display("FAIL carry_chain_result: got done=%b %b_%h expected 1 1_00000000", done, carry_out, result);
        end
        tick();
    endtask

    task automatic test_ignored_start();
        logic [W-1:0] a1, b1;
        logic [W:0]   exp;
        int           lat;
        a1  = $urandom;
        b1  = $urandom;
        exp = ref_op(a1, b1, 1'b0);
        start_op(a1, b1);
        tick();
        op_a = $urandom; op_b = $urandom; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        vectors++;
        if (done !== 1'b1 || {carry_out, result} !== exp) begin
            errors++;
            $display("FAIL ignore_result: got done=%b %b_%h expected 1 %b_%h", done, carry_out, result, exp[W], exp[W-1:0]);
        end
        op_a = $urandom; op_b = $urandom; start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || {carry_out, result} !== exp) begin
            errors++;
            $display("FAIL ignore_done_start: got busy=%b done=%b %b_%h", busy, done, carry_out, result);
        end
        a1  = $urandom;
        b1  = $urandom;
        exp = ref_op(a1, b1, 1'b0);
        start_op(a1, b1);
        vectors++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL ignore_idle_accept: busy got %b expected 1", busy);
        end
        wait_done(lat);
        vectors++;
        if (done !== 1'b1 || {carry_out, result} !== exp) begin
            errors++;
            $display("FAIL ignore_next_result: got done=%b %b_%h expected %b_%h", done, carry_out, result, exp[W], exp[W-1:0]);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [W:0] exp;
        int         lat;
        start_op(32'hFFFF_FFFF, 32'h0000_0001);
        tick();
        tick();
        reset = 1'b1;
        tick();
        vectors++;
        if ({busy, done, carry_out, add_cin} !== 4'b0 || result !== '0 || add_a !== '0 || add_b !== '0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b done=%b cout=%b cin=%b res=%h a=%h b=%h",
                     busy, done, carry_out, add_cin, result, add_a, add_b);
        end
        reset = 1'b0;
        tick();
        exp = ref_op(32'h1234_5678, 32'h0000_0000, 1'b0);
        start_op(32'h1234_5678, 32'h0000_0000);
        wait_done(lat);
        vectors++;
        if (done !== 1'b1 || {carry_out, result} !== exp) begin
            errors++;
            $display("FAIL reset_mid_recover: got done=%b %b_%h expected %b_%h", done, carry_out, result, exp[W], exp[W-1:0]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] as [5];
        logic [W-1:0] bs [5];
        logic [W:0]   exp;
        logic [W-1:0] held;
        int n, last_done, cyc;
        for (int i = 0; i < 5; i++) begin
            as[i] = $urandom;
            bs[i] = $urandom;
        end
        n = 0; last_done = -1; cyc = 1; held = '0;
        op_a = as[0]; op_b = bs[0]; start = 1'b1;
        tick();
        while (n < 5 && cyc < 100) begin
            if (done === 1'b1) begin
                exp = ref_op(as[n], bs[n], 1'b0);
                vectors++;
                if ({carry_out, result} !== exp) begin
                    errors++;
                    $display("FAIL b2b_result op%0d: got %b_%h expected %b_%h", n, carry_out, result, exp[W], exp[W-1:0]);
                end
                if (n > 0) begin
                    vectors++;
                    if (cyc - last_done != WORDS + 2) begin
                        errors++;
                        $display("FAIL b2b_period op%0d: got %0d expected %0d", n, cyc - last_done, WORDS + 2);
                    end
                end
                last_done = cyc;
                held = result;
                n++;
                if (n < 5) begin
                    op_a = as[n];
                    op_b = bs[n];
                end else begin
                    start = 1'b0;
                end
            end else if (last_done >= 0 && cyc == last_done + 1) begin
                vectors++;
                if (result !== held) begin
                    errors++;
                    $display("FAIL b2b_hold: got %h expected %h", result, held);
                end
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        vectors++;
        if (n != 5) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d ops expected 5", n);
        end
        tick();
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic [W:0]   exp;
        int           lat;
        for (int i = 0; i < 20; i++) begin
            a = (i == 0) ? '0 : (i == 1) ? '1 : W'($urandom);
            b = (i == 0) ? '0 : (i == 1) ? '1 : W'($urandom);
            exp = ref_op(a, b, 1'b0);
            start_op(a, b);
            wait_done(lat);
            vectors++;
            if (done !== 1'b1 || lat != WORDS + 1) begin
                errors++;
                $display("FAIL rand_latency %0d: got done=%b lat=%0d expected %0d", i, done, lat, WORDS + 1);
            end
            vectors++;
            if ({carry_out, result} !== exp) begin
                errors++;
                $display("FAIL rand_result %0d: a=%h b=%h got %b_%h expected %b_%h", i, a, b, carry_out, result, exp[W], exp[W-1:0]);
            end
            tick();
        end
    endtask

`ifdef WORD_SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        logic [W-1:0] a, b;
        logic [W:0]   exp;
        int           lat;
        sub = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = (i == 0) ? W'(5) : (i == 1) ? W'(7) : W'($urandom);
            b = (i == 0) ? W'(7) : (i == 1) ? W'(5) : W'($urandom);
            exp = ref_op(a, b, 1'b1);
            start_op(a, b);
            wait_done(lat);
            vectors++;
            if (done !== 1'b1 || {carry_out, result} !== exp) begin
                errors++;
                $display("FAIL sub_result %0d: a=%h b=%h got %b_%h expected %b_%h", i, a, b, carry_out, result, exp[W], exp[W-1:0]);
            end
            tick();
        end
        sub = 1'b0;
    endtask
`endif

    initial begin
`ifdef WORD_SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        test_reset();
        test_directed();
        test_carry_chain();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef WORD_SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
